fdiv_pipe: RTL and testbench

//  Pipelined IEEE-754 single-precision divider y = x1 / x2, built as the consumer of finv.

---
 rtl/fdiv_pipe.sv | 205 ++++++++++++++++++++
 tb/tb_fdiv_pipe.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/fdiv_pipe.sv
// Pipelined IEEE-754 single-precision divider y = x1 / x2.
// The divisor goes straight into finv. The dividend, tag, class and valid bit
// travel down a matching delay line. A two-stage multiply/normalise/round
// back end forms x1 * finv(x2). The pipe accepts one op per cycle and never stalls.

// Reciprocal unit: y = 1/x after LAT register stages. Zero/denormal inputs give
// INF. INF/NaN inputs give zero. Reciprocals below the normal range are flushed.
module finv #(
  parameter int LAT = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] x,
  output logic [31:0] y
);

  logic [23:0]        d;
  logic [49:0]        num;
  logic [49:0]        den;
  logic [24:0]        rq;
  logic signed [9:0]  e;
  logic signed [9:0]  er;
  logic [31:0]        yc;
  logic [31:0]        pipe [LAT];

  // rq = round(2^47 / {1,m}); bit 24 is set only for an exact power of two
  assign d   = {1'b1, x[22:0]};
  assign num = {2'b01, 48'h0} + {26'h0, d};
  assign den = {25'h0, d, 1'b0};
  assign rq  = 25'(num / den);
  assign e   = $signed({2'b00, x[30:23]});

  // reciprocal exponent, special cases and flush-to-zero
  always_comb begin
    yc = {x[31], 31'h0};
    if (rq[24]) er = 10'sd254 - e;
    else        er = 10'sd253 - e;
    if (x[30:23] == 8'h00)      yc = {x[31], 8'hff, 23'h0};
    else if (x[30:23] == 8'hff) yc = {x[31], 31'h0};
    else if (er <= 10'sd0)      yc = {x[31], 31'h0};
    else if (rq[24])            yc = {x[31], er[7:0], rq[23:1]};
    else                        yc = {x[31], er[7:0], rq[22:0]};
  end

  // latency pipe so the consumer sees a fixed LAT-cycle reciprocal
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < LAT; i++) pipe[i] <= 32'h0;
    end else begin
      pipe[0] <= yc;
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign y = pipe[LAT-1];

endmodule

module fdiv_pipe #(
  parameter int FINV_LAT = 2,
  parameter int TAG_W    = 5
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  input  logic [31:0]      x1,
  input  logic [31:0]      x2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  output logic [31:0]      y,
  output logic [TAG_W-1:0] out_tag
);

  typedef enum logic [1:0] {CLS_NORM = 2'd0, CLS_ZERO = 2'd1, CLS_INF = 2'd2} cls_t;

  logic [31:0]        finv_y;
  cls_t               cls_in;

  logic               dv   [FINV_LAT];
  logic [TAG_W-1:0]   dtag [FINV_LAT];
  logic [31:0]        dx1  [FINV_LAT];
  cls_t               dcls [FINV_LAT];

  logic               a_valid;
  logic [TAG_W-1:0]   a_tag;
  logic               a_sign;
  cls_t               a_cls;
  logic               a_flush;
  logic [47:0]        a_p;
  logic signed [9:0]  a_e;

  logic [22:0]        mant_n;
  logic               guard;
  logic               sticky;
  logic signed [9:0]  e_n;
  logic [23:0]        rnd;
  logic signed [9:0]  e_r;
  logic [31:0]        res;

  finv #(.LAT(FINV_LAT)) u_finv (
    .clk  (clk),
    .rstn (rstn),
    .x    (x2),
    .y    (finv_y)
  );

  // operand class, first match wins; denormals count as zero
  always_comb begin
    cls_in = CLS_NORM;
    if (x1[30:23] == 8'hff)      cls_in = CLS_INF;
    else if (x2[30:23] == 8'h00) cls_in = CLS_INF;
    else if (x1[30:23] == 8'h00) cls_in = CLS_ZERO;
    else if (x2[30:23] == 8'hff) cls_in = CLS_ZERO;
  end

  // delay line matching finv latency
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < FINV_LAT; i++) begin
        dv[i]   <= 1'b0;
        dtag[i] <= '0;
        dx1[i]  <= 32'h0;
        dcls[i] <= CLS_NORM;
      end
    end else begin
      dv[0]   <= in_valid;
      dtag[0] <= in_tag;
      dx1[0]  <= x1;
      dcls[0] <= cls_in;
      for (int i = 1; i < FINV_LAT; i++) begin
        dv[i]   <= dv[i-1];
        dtag[i] <= dtag[i-1];
        dx1[i]  <= dx1[i-1];
        dcls[i] <= dcls[i-1];
      end
    end
  end

  // stage A: mantissa product and biased exponent sum; finv keeps the divisor
  // sign, so the quotient sign comes from x1 and the reciprocal together
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      a_valid <= 1'b0;
      a_tag   <= '0;
      a_sign  <= 1'b0;
      a_cls   <= CLS_NORM;
      a_flush <= 1'b0;
      a_p     <= 48'h0;
      a_e     <= 10'sd0;
    end else begin
      a_valid <= dv[FINV_LAT-1];
      a_tag   <= dtag[FINV_LAT-1];
      a_sign  <= dx1[FINV_LAT-1][31] ^ finv_y[31];
      a_cls   <= dcls[FINV_LAT-1];
      a_flush <= (finv_y[30:23] == 8'h00);
      a_p     <= {24'h0, 1'b1, dx1[FINV_LAT-1][22:0]} * {24'h0, 1'b1, finv_y[22:0]};
      a_e     <= $signed({2'b00, dx1[FINV_LAT-1][30:23]})
               + $signed({2'b00, finv_y[30:23]}) - 10'sd127;
    end
  end

  // stage B datapath: normalise, round to nearest-even, range and class select
  always_comb begin
    if (a_p[47]) begin
      mant_n = a_p[46:24];
      guard  = a_p[23];
      sticky = |a_p[22:0];
      e_n    = a_e + 10'sd1;
    end else begin
      mant_n = a_p[45:23];
      guard  = a_p[22];
      sticky = |a_p[21:0];
      e_n    = a_e;
    end
    rnd = {1'b0, mant_n} + {23'h0, guard & (sticky | mant_n[0])};
    e_r = rnd[23] ? e_n + 10'sd1 : e_n;
    res = {a_sign, 31'h0};
    case (a_cls)
      CLS_INF:  res = {a_sign, 8'hff, 23'h0};
      CLS_ZERO: res = {a_sign, 31'h0};
      default: begin
        if (a_flush)              res = {a_sign, 31'h0};
        else if (e_r >= 10'sd255) res = {a_sign, 8'hff, 23'h0};
        else if (e_r <= 10'sd0)   res = {a_sign, 31'h0};
        else                      res = {a_sign, e_r[7:0], rnd[22:0]};
      end
    endcase
  end

  // stage B registers: result and tag update only for valid ops, else hold
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid <= 1'b0;
      y         <= 32'h0;
      out_tag   <= '0;
    end else begin
      out_valid <= a_valid;
      if (a_valid) begin
        y       <= res;
        out_tag <= a_tag;
      end
    end
  end

endmodule

// File: tb/tb_fdiv_pipe.sv
// Bench for fdiv_pipe: table vectors, random stream against a real-number
// model, valid-gap pattern and mid-stream reset, all through a scoreboard.
module tb_fdiv_pipe;

  localparam int FINV_LAT = 2;
  localparam int TAG_W    = 5;
  localparam int L        = FINV_LAT + 2;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             in_valid = 1'b0;
  logic [31:0]      x1 = 32'h0;
  logic [31:0]      x2 = 32'h0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic [31:0]      y;
  logic [TAG_W-1:0] out_tag;

  typedef struct {
    logic [31:0]      x1;
    logic [31:0]      x2;
    logic [TAG_W-1:0] tag;
    logic [31:0]      q;
    int               tol;
  } vec_t;

  typedef struct {
    logic [31:0]      q;
    logic [TAG_W-1:0] tag;
    int               tol;
    int               cyc;
  } exp_t;

  exp_t             sb[$];
  exp_t             last;
  bit               have_last = 1'b0;
  int               cyc = 0;
  int               n_cmp = 0;
  int               n_bad = 0;
  vec_t             vecs[13];

  fdiv_pipe #(.FINV_LAT(FINV_LAT), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .x1        (x1),
    .x2        (x2),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .y         (y),
    .out_tag   (out_tag)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic real to_real(input logic [31:0] b);
    real v;
    int  e;
    v = 1.0 + real'(b[22:0]) / 8388608.0;
    e = int'(b[30:23]) - 127;
    while (e > 0) begin v = v * 2.0; e--; end
    while (e < 0) begin v = v / 2.0; e++; end
    return b[31] ? -v : v;
  endfunction

  function automatic logic [31:0] from_real(input real vin);
    real         v;
    logic        s;
    int          e;
    logic [23:0] m;
    s = (vin < 0.0);
    v = s ? -vin : vin;
    e = 127;
    while (v >= 2.0) begin v = v / 2.0; e++; end
    while (v < 1.0)  begin v = v * 2.0; e--; end
    m = 24'($rtoi((v - 1.0) * 8388608.0 + 0.5));
    if (m[23]) begin m = 24'h0; e++; end
    return {s, 8'(e), m[22:0]};
  endfunction

  function automatic bit close(input logic [31:0] a, input logic [31:0] e, input int tol);
    int d;
    if (tol == 0) return a == e;
    if (a[31] != e[31]) return 1'b0;
    d = int'(a[30:0]) - int'(e[30:0]);
    if (d < 0) d = -d;
    return d <= tol;
  endfunction

  task automatic check(input string name, input bit ok, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] t,
                       input logic [31:0] q, input int tol);
    exp_t e;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    x1 = a;
    x2 = b;
    in_tag = t;
    e.q = q;
    e.tag = t;
    e.tol = tol;
    e.cyc = cyc + L;
    sb.push_back(e);
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    x1 = $urandom;
    x2 = $urandom;
    in_tag = TAG_W'($urandom);
  endtask

  task automatic drain();
    for (int i = 0; i < L + 3; i++) idle();
    check("sb_empty", sb.size() == 0, 32'(sb.size()), 32'h0);
  endtask

  // output monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (!rstn) begin
      check("rst_valid", out_valid == 1'b0, {31'h0, out_valid}, 32'h0);
      check("rst_y", y == 32'h0, y, 32'h0);
      check("rst_tag", out_tag == '0, 32'(out_tag), 32'h0);
    end else if (out_valid) begin
      check("valid_expected", sb.size() != 0, {31'h0, out_valid}, 32'h0);
      if (sb.size() != 0) begin
        last = sb.pop_front();
        have_last = 1'b1;
        check("y", close(y, last.q, last.tol), y, last.q);
        check("tag", out_tag == last.tag, 32'(out_tag), 32'(last.tag));
        check("latency", cyc == last.cyc, 32'(cyc), 32'(last.cyc));
      end
    end else if (have_last) begin
      check("hold_y", close(y, last.q, last.tol), y, last.q);
      check("hold_tag", out_tag == last.tag, 32'(out_tag), 32'(last.tag));
    end else begin
      check("idle_y", y == 32'h0, y, 32'h0);
      check("idle_tag", out_tag == '0, 32'(out_tag), 32'h0);
    end
  end

  initial begin
    logic [31:0] a, b;
    vecs[0]  = '{32'h40C00000, 32'h40400000, 5'd3,  32'h40000000, 2};
    vecs[1]  = '{32'h3F800000, 32'h00000000, 5'd1,  32'h7F800000, 0};
    vecs[2]  = '{32'h80000000, 32'h40A00000, 5'd2,  32'h80000000, 0};
    vecs[3]  = '{32'hC37F0000, 32'h437F0000, 5'd4,  32'hBF800000, 2};
    vecs[4]  = '{32'h7F000000, 32'h00800000, 5'd5,  32'h7F800000, 0};
    vecs[5]  = '{32'h3F800000, 32'h7F800000, 5'd6,  32'h00000000, 0};
    vecs[6]  = '{32'hFF800000, 32'h40000000, 5'd7,  32'hFF800000, 0};
    vecs[7]  = '{32'h40000000, 32'h7F000000, 5'd8,  32'h00000000, 0};
    vecs[8]  = '{32'h00800000, 32'h40000000, 5'd9,  32'h00000000, 0};
    vecs[9]  = '{32'h3F800000, 32'hC0800000, 5'd10, 32'hBE800000, 0};
    vecs[10] = '{32'h3F800000, 32'h40400000, 5'd11, 32'h3EAAAAAB, 2};
    vecs[11] = '{32'h7F800000, 32'h00000000, 5'd12, 32'h7F800000, 0};
    vecs[12] = '{32'h00000000, 32'h00000000, 5'd13, 32'h7F800000, 0};

    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    idle();
    idle();

    // single op first, then the table back-to-back
    issue(vecs[0].x1, vecs[0].x2, vecs[0].tag, vecs[0].q, vecs[0].tol);
    drain();
    for (int i = 0; i < 13; i++)
      issue(vecs[i].x1, vecs[i].x2, vecs[i].tag, vecs[i].q, vecs[i].tol);
    drain();

    // random normal stream, tag = index
    for (int i = 0; i < 64; i++) begin
      a = {1'($urandom), 8'($urandom_range(154, 100)), 23'($urandom)};
      b = {1'($urandom), 8'($urandom_range(154, 100)), 23'($urandom)};
      issue(a, b, TAG_W'(i), from_real(to_real(a) / to_real(b)), 2);
    end
    drain();

    // valid pattern 1,0,0,1,1,0
    issue(32'h40C00000, 32'h40400000, 5'd20, 32'h40000000, 2);
    idle();
    idle();
    issue(32'h3F800000, 32'hC0800000, 5'd21, 32'hBE800000, 0);
    issue(32'h3F800000, 32'h00000000, 5'd22, 32'h7F800000, 0);
    idle();
    drain();

    // four ops in flight, then a one-cycle reset
    issue(32'h40C00000, 32'h40400000, 5'd24, 32'h40000000, 2);
    issue(32'h3F800000, 32'h40400000, 5'd25, 32'h3EAAAAAB, 2);
    issue(32'h3F800000, 32'hC0800000, 5'd26, 32'hBE800000, 0);
    issue(32'h80000000, 32'h40A00000, 5'd27, 32'h80000000, 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rstn = 1'b0;
    sb.delete();
    have_last = 1'b0;
    @(posedge clk);
    #1 rstn = 1'b1;
    idle();
    issue(32'hC37F0000, 32'h437F0000, 5'd30, 32'hBF800000, 2);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
